// File: rtl/draw_platform_pkg.sv
// Shared widths, colour key and timing/pixel bundle layout for the platform tile drawer.
package draw_platform_pkg;

  localparam int unsigned H_BITS      = 11;
  localparam int unsigned RGB_BITS    = 12;
  localparam int unsigned POS_BITS    = 12;
  localparam int unsigned LEN_BITS    = 6;
  localparam int unsigned TILE_BITS   = 4;
  localparam int unsigned TILE_PX     = 1 << TILE_BITS;
  localparam int unsigned ADDR_BITS   = 2 * TILE_BITS;
  localparam int unsigned CMP_BITS    = 13;
  localparam int unsigned BUNDLE_BITS = 2 * H_BITS + 4 + RGB_BITS;

  localparam logic [RGB_BITS-1:0] KEY_RGB_DEF = 12'hF0F;

  typedef struct packed {
    logic [H_BITS-1:0]   hcount;
    logic [H_BITS-1:0]   vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
    logic [RGB_BITS-1:0] rgb;
  } bundle_t;

endpackage

// File: rtl/signal_delay.sv
// Fixed-depth register delay line with asynchronous active-low clear.
module signal_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign data_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/draw_platform.sv
// Draws a horizontal run of 16x16 ROM tiles over the pixel stream; 3-cycle matched latency.
module draw_platform
  import draw_platform_pkg::*;
#(
  parameter int unsigned         MAX_TILES = 32,
  parameter logic [RGB_BITS-1:0] KEY_RGB   = KEY_RGB_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [H_BITS-1:0]    hcount_in,
  input  logic [H_BITS-1:0]    vcount_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 hblnk_in,
  input  logic                 vblnk_in,
  input  logic [RGB_BITS-1:0]  rgb_in,
  input  logic [POS_BITS-1:0]  xpos,
  input  logic [POS_BITS-1:0]  ypos,
  input  logic [LEN_BITS-1:0]  len,
  input  logic                 pos_valid,
  output logic                 pos_ack,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [RGB_BITS-1:0]  rom_rgb,
  output logic [H_BITS-1:0]    hcount_out,
  output logic [H_BITS-1:0]    vcount_out,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 hblnk_out,
  output logic                 vblnk_out,
  output logic [RGB_BITS-1:0]  rgb_out
);

  logic                 vblnk_q, armed_q, vblnk_rise, accept;
  logic                 pos_ack_q;
  logic [POS_BITS-1:0]  x_act_q, y_act_q;
  logic [LEN_BITS-1:0]  len_act_q, len_clamped;

  // armed_q blocks a false rising edge when vblnk_in is already high at reset release.
  assign vblnk_rise  = vblnk_in & ~vblnk_q & armed_q;
  assign accept      = vblnk_rise & pos_valid;
  assign len_clamped = (32'(len) > MAX_TILES) ? LEN_BITS'(MAX_TILES) : len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q   <= 1'b0;
      armed_q   <= 1'b0;
      pos_ack_q <= 1'b0;
      x_act_q   <= '0;
      y_act_q   <= '0;
      len_act_q <= '0;
    end else begin
      vblnk_q   <= vblnk_in;
      pos_ack_q <= accept;
      if (!vblnk_in) armed_q <= 1'b1;
      if (accept) begin
        x_act_q   <= xpos;
        y_act_q   <= ypos;
        len_act_q <= len_clamped;
      end
    end
  end

  assign pos_ack = pos_ack_q;

  logic [CMP_BITS-1:0]  h_ext, v_ext, x_lo, x_hi, y_lo, y_hi;
  logic [TILE_BITS-1:0] rel_x, rel_y;
  logic                 hit1_d, hit1_q, hit2_q;
  logic [ADDR_BITS-1:0] rom_addr_q;

  assign h_ext = CMP_BITS'(hcount_in);
  assign v_ext = CMP_BITS'(vcount_in);
  assign x_lo  = CMP_BITS'(x_act_q);
  assign x_hi  = x_lo + (CMP_BITS'(len_act_q) << TILE_BITS);
  assign y_lo  = CMP_BITS'(y_act_q);
  assign y_hi  = y_lo + CMP_BITS'(TILE_PX);

  assign hit1_d = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi) &&
                  !hblnk_in && !vblnk_in;

  // Only the low bits of the offset matter, so the tile pattern repeats every 16 px.
  assign rel_x = hcount_in[TILE_BITS-1:0] - x_act_q[TILE_BITS-1:0];
  assign rel_y = vcount_in[TILE_BITS-1:0] - y_act_q[TILE_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      hit1_q     <= hit1_d;
      hit2_q     <= hit1_q;
      rom_addr_q <= {rel_y, rel_x};
    end
  end

  assign rom_addr = rom_addr_q;

  bundle_t in_b, dly_b, out_q;

  assign in_b = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

  signal_delay #(
    .WIDTH (BUNDLE_BITS),
    .DEPTH (2)
  ) u_stream_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (in_b),
    .data_o (dly_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q     <= dly_b;
      out_q.rgb <= (hit2_q && (rom_rgb != KEY_RGB)) ? rom_rgb : dly_b.rgb;
    end
  end

  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign hblnk_out  = out_q.hblnk;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_platform.sv
// Bench for draw_platform: directed vectors plus random stream against a behavioural model.
module tb_draw_platform;

  localparam logic [11:0] KEY = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [11:0] xpos = '0, ypos = '0;
  logic [5:0]  len = '0;
  logic        pos_valid = 1'b0;
  logic        pos_ack;
  logic [7:0]  rom_addr;
  logic [11:0] rom_rgb = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  draw_platform dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .len        (len),
    .pos_valid  (pos_valid),
    .pos_ack    (pos_ack),
    .rom_addr   (rom_addr),
    .rom_rgb    (rom_rgb),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  // Tile ROM: pixel = {addr,4'h0}, except one transparent texel.
  function automatic logic [11:0] rom_fn(input logic [7:0] a);
    return (a == 8'h55) ? KEY : {a, 4'h0};
  endfunction

  always_ff @(posedge clk) rom_rgb <= rom_fn(rom_addr);

  typedef struct {
    int          h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    int          xa, ya, la;
  } ent_t;

  typedef struct {
    int          h, v;
    logic        hb;
    logic [11:0] rgb;
    logic [7:0]  ea;
    logic [11:0] er;
  } vec_t;

  ent_t hist[$];
  int   m_x, m_y, m_len;
  bit   m_prev_vb, exp_ack;
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_addr(input ent_t e);
    int rx, ry;
    rx = (e.h - e.xa) & 15;
    ry = (e.v - e.ya) & 15;
    return 8'(ry * 16 + rx);
  endfunction

  function automatic logic [11:0] exp_rgb(input ent_t e);
    bit          hit;
    logic [11:0] p;
    hit = e.h >= e.xa && e.h < e.xa + 16 * e.la && e.v >= e.ya && e.v < e.ya + 16 &&
          !e.hb && !e.vb;
    p = rom_fn(exp_addr(e));
    return (hit && p != KEY) ? p : e.rgb;
  endfunction

  task automatic reset_model();
    ent_t z = '{default: 0};
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    m_x = 0; m_y = 0; m_len = 0;
    m_prev_vb = 1'b1;
    exp_ack = 1'b0;
  endtask

  // One clock: record the inputs about to be sampled, advance, then check outputs.
  task automatic step();
    ent_t e;
    bit   acc;
    e.h = int'(hcount_in); e.v = int'(vcount_in);
    e.hs = hsync_in; e.vs = vsync_in; e.hb = hblnk_in; e.vb = vblnk_in;
    e.rgb = rgb_in;
    e.xa = m_x; e.ya = m_y; e.la = m_len;
    hist.push_back(e);
    acc = vblnk_in && !m_prev_vb && pos_valid;
    if (acc) begin
      m_x = int'(xpos);
      m_y = int'(ypos);
      m_len = (int'(len) > 32) ? 32 : int'(len);
    end
    m_prev_vb = vblnk_in;
    exp_ack = acc;
    @(posedge clk);
    #1;
    chk("pos_ack", 64'(pos_ack), 64'(exp_ack));
    chk("rom_addr", 64'(rom_addr), 64'(exp_addr(hist[$])));
    chk("rgb_out", 64'(rgb_out), 64'(exp_rgb(hist[0])));
    chk("timing", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
        64'({11'(hist[0].h), 11'(hist[0].v), hist[0].hs, hist[0].vs, hist[0].hb, hist[0].vb}));
    void'(hist.pop_front());
  endtask

  task automatic chk_zero(input string name);
    chk(name, 64'({pos_ack, rom_addr, rgb_out, hcount_out, vcount_out, hsync_out, vsync_out,
                   hblnk_out, vblnk_out}), 64'(0));
  endtask

  task automatic req(input int x, input int y, input int l);
    xpos = 12'(x); ypos = 12'(y); len = 6'(l);
    pos_valid = 1'b1;
    hblnk_in = 1'b0;
    vblnk_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ack_before_edge", 64'(pos_ack), 64'(0));
    end
    vblnk_in = 1'b1;
    step();
    chk("ack_after_edge", 64'(pos_ack), 64'(1));
    pos_valid = 1'b0;
    step();
    chk("ack_single", 64'(pos_ack), 64'(0));
    vblnk_in = 1'b0;
    step();
  endtask

  task automatic run_vec(input vec_t t);
    hcount_in = 11'(t.h); vcount_in = 11'(t.v);
    hblnk_in = t.hb; vblnk_in = 1'b0; rgb_in = t.rgb;
    step();
    chk("vec_addr", 64'(rom_addr), 64'(t.ea));
    step();
    step();
    chk("vec_rgb", 64'(rgb_out), 64'(t.er));
  endtask

  vec_t plat_tbl[9];
  vec_t clamp_tbl[2];
  vec_t zero_vec;

  initial begin
    plat_tbl[0] = '{117, 203, 1'b0, 12'hABC, 8'h31, 12'h310};
    plat_tbl[1] = '{100, 200, 1'b0, 12'h123, 8'h00, 12'h000};
    plat_tbl[2] = '{147, 215, 1'b0, 12'h456, 8'hFF, 12'hFF0};
    plat_tbl[3] = '{148, 200, 1'b0, 12'h789, 8'h00, 12'h789};
    plat_tbl[4] = '{99,  200, 1'b0, 12'h321, 8'h0F, 12'h321};
    plat_tbl[5] = '{120, 199, 1'b0, 12'h654, 8'hF4, 12'h654};
    plat_tbl[6] = '{120, 216, 1'b0, 12'h987, 8'h04, 12'h987};
    plat_tbl[7] = '{105, 205, 1'b0, 12'hCDE, 8'h55, 12'hCDE};
    plat_tbl[8] = '{130, 210, 1'b1, 12'h0AA, 8'hAE, 12'h0AA};
    clamp_tbl[0] = '{551, 8, 1'b0, 12'h111, 8'h0F, 12'h0F0};
    clamp_tbl[1] = '{552, 8, 1'b0, 12'h222, 8'h00, 12'h222};
    zero_vec     = '{40,  8, 1'b0, 12'h333, 8'h00, 12'h333};

    // Reset state, with vblnk high across release.
    vblnk_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    #3;
    rst_n = 1'b1;
    reset_model();
    pos_valid = 1'b1;
    xpos = 12'd10; ypos = 12'd10; len = 6'd4;
    step();
    chk("no_spurious_edge", 64'(pos_ack), 64'(0));
    pos_valid = 1'b0;

    // Pass-through with no request.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 30) == 0) vblnk_in = ~vblnk_in;
      hblnk_in = ($urandom_range(0, 7) == 0);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      hcount_in = 11'($urandom); vcount_in = 11'($urandom);
      rgb_in = 12'($urandom);
      step();
    end
    hsync_in = 1'b0; vsync_in = 1'b0;

    req(100, 200, 3);
    foreach (plat_tbl[i]) run_vec(plat_tbl[i]);

    req(40, 8, 63);
    foreach (clamp_tbl[i]) run_vec(clamp_tbl[i]);
    req(40, 8, 0);
    run_vec(zero_vec);

    // Random requests and stream aimed around the active platform.
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (!pos_valid && $urandom_range(0, 30) == 0) begin
        pos_valid = 1'b1;
        xpos = 12'($urandom_range(0, 1100));
        ypos = 12'($urandom_range(0, 700));
        len = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 40) == 0) vblnk_in = ~vblnk_in;
      hblnk_in = ($urandom_range(0, 9) == 0);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      r = int'($urandom_range(0, 16 * m_len + 40));
      hcount_in = 11'(m_x + r - 20);
      r = int'($urandom_range(0, 24));
      vcount_in = 11'(m_y + r - 4);
      rgb_in = 12'($urandom);
      step();
      if (exp_ack) pos_valid = 1'b0;
    end
    pos_valid = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Asynchronous reset mid-line with platform drawing.
    req(100, 200, 3);
    hcount_in = 11'd117; vcount_in = 11'd203; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'hABC;
    repeat (3) step();
    chk("pre_reset_draw", 64'(rgb_out), 64'(12'h310));
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    reset_model();
    repeat (3) step();
    chk("post_reset_invisible", 64'(rgb_out), 64'(12'hABC));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_platform.md
# draw_platform

Tiled sprite reader for the VGA overlay chain: draws one horizontal platform of `len` 16×16 tiles at (`xpos`,`ypos`) by issuing addresses to an external synchronous tile ROM (8-bit address `{y[3:0],x[3:0]}`, 12-bit RGB, one-cycle read latency) and merging returned pixels over the incoming stream. Sits between two draw stages in the pixel pipeline; timing signals pass through with matched delay. Position changes are accepted only at vertical-blank start, so a platform never tears mid-frame.

## Interface
- `MAX_TILES`, 32, upper clamp on platform length in tiles
- `KEY_RGB`, 12'hF0F, transparent colour; ROM pixels equal to it are not drawn
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous, active-low reset
- `hcount_in`, `vcount_in`  in  11 each  pixel coordinates from the upstream stage
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1 each  upstream timing
- `rgb_in`  in  12  upstream pixel
- `xpos`, `ypos`  in  12 each  requested top-left corner (unsigned)
- `len`  in  6  requested length in tiles
- `pos_valid`  in  1  request to load `xpos/ypos/len`
- `pos_ack`  out  1  one-cycle pulse: request accepted
- `rom_addr`  out  8  tile ROM address `{rel_y[3:0], rel_x[3:0]}`
- `rom_rgb`  in  12  tile ROM data, valid one cycle after `rom_addr`
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`, `rgb_out`  out  as inputs  delayed stream

## Operation
- Active registers `x_act`, `y_act`, `len_act`; reset to 0/0/0 (platform invisible).
- Update handshake: `vblnk_in` rising edge detected via a registered copy. On an edge cycle with `pos_valid=1`: load active regs, `len_act = min(len, MAX_TILES)`, assert `pos_ack` for exactly one cycle. `pos_valid` without an edge: wait, no ack. Requester holds `pos_valid` until `pos_ack`, drops it the cycle after. `pos_valid` rising in the same cycle as the edge is accepted.
- Stage 1 (register): `hit1 = hcount_in >= x_act && hcount_in < x_act + 16*len_act && vcount_in >= y_act && vcount_in < y_act + 16 && !hblnk_in && !vblnk_in`. Compare in 13 bits; no wrap. `rom_addr <= {(vcount_in-y_act)[3:0], (hcount_in-x_act)[3:0]}`; tile repeats every 16 px horizontally.
- Stage 2: ROM returns `rom_rgb`; `hit` forwarded as `hit2`.
- Stage 3 (register): `rgb_out <= (hit2 && rom_rgb != KEY_RGB) ? rom_rgb : rgb_in delayed 2`.
- `len_act=0`: never hits; output equals input delayed.
- Platform partially off-screen (x_act+16*len_act > 1023): draws visible part only; blanking masks the rest.

## Timing
- Every output `*_out` lags its input by exactly 3 clocks; `rom_addr` lags `hcount_in/vcount_in` by 1.
- Reset values: all outputs 0, `pos_ack=0`, `rom_addr=0`, edge detector 0 (no spurious edge if `vblnk_in=1` at reset release: first edge requires a seen 0).
- Reset asserted mid-frame: pipeline and active regs clear immediately; stream restarts 3 cycles after release.
- Active-register update happens at blank start; first pixel using new values is 3 cycles after the next visible line entry.

## Structure
- Shared package: `H_BITS=11`, `RGB_BITS=12`, `TILE_BITS=4` (tile side 16), `KEY_RGB` default, timing-bundle width.
- Sub-module `signal_delay` (params WIDTH, DEPTH; async active-low reset to 0) delays the 38-bit timing/rgb bundle (3 stages for timing, 2 for `rgb_in`).
- ROM itself instantiated by the parent, not inside this block.

## Test plan
- Reset, then hold `pos_valid=0`: `rgb_out` equals `rgb_in` delayed 3 cycles for a whole frame; `pos_ack` never rises.
- `pos_valid` with x=100,y=200,len=3 mid-frame: no ack until `vblnk_in` rises; ack one cycle after the edge, single pulse; next frame pixels x∈[100,147], y∈[200,215] take ROM data, x=148 passes `rgb_in`.
- ROM model returning `{addr,4'h0}`: at hcount=117,vcount=203 `rom_addr=8'h31` one cycle later; `rgb_out=12'h310` three cycles after input.
- ROM pixel = 12'hF0F inside platform: `rgb_out` equals delayed `rgb_in`.
- len=63: clamped to 32; last drawn x = x_act+511. len=0: nothing drawn.
- `rst_n` pulsed low mid-line with platform active: all outputs 0 asynchronously; after release, platform invisible until new accepted request.
